// File: rtl/circ_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : circ_pkg
//  Description : Shared definitions for the circular interpolator: FSM state
//                encoding, default coordinate width and quadrant helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package circ_pkg;

    // Default signed coordinate width for positions and end points.
    localparam int COORD_W_DEF = 16;

    // FSM state encoding. The 3-bit width matches the speed_clk block.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;

    // Quadrant identified by the sign bits {sx, sy} of a point.
    typedef enum logic [1:0] {
        QUAD_1 = 2'b00,
        QUAD_4 = 2'b01,
        QUAD_2 = 2'b10,
        QUAD_3 = 2'b11
    } quad_t;

    // Quadrants 2 and 4 mirror the rotation sense when the arc is walked on
    // magnitudes, so the step rule flips there.
    function automatic logic quad_mirror(input quad_t q);
        return (q == QUAD_2) || (q == QUAD_4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/circ_interp_if.sv
`default_nettype none
// ============================================================================
//  Module      : circ_interp_if
//  Description : Command, pulse and motor-step bundle of the circular
//                interpolator. master = controller side, slave = core side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface circ_interp_if
    import circ_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
);
    // Command side
    logic                      start;
    logic                      stop;
    logic                      ccw;
    logic signed [COORD_W-1:0] x_start;
    logic signed [COORD_W-1:0] y_start;
    logic signed [COORD_W-1:0] x_end;
    logic signed [COORD_W-1:0] y_end;
    logic                      pulse_clk;

    // Motor driver and status side
    logic                      x_step;
    logic                      y_step;
    logic                      x_dir;
    logic                      y_dir;
    logic signed [COORD_W-1:0] x_pos;
    logic signed [COORD_W-1:0] y_pos;
    logic                      busy;
    logic                      change_readyH;
    logic                      draw_overH;
    logic                      err;

    modport master (
        output start, stop, ccw, x_start, y_start, x_end, y_end, pulse_clk,
        input  x_step, y_step, x_dir, y_dir, x_pos, y_pos,
               busy, change_readyH, draw_overH, err
    );

    modport slave (
        input  start, stop, ccw, x_start, y_start, x_end, y_end, pulse_clk,
        output x_step, y_step, x_dir, y_dir, x_pos, y_pos,
               busy, change_readyH, draw_overH, err
    );

endinterface
`default_nettype wire

// File: rtl/circ_step_core.sv
`default_nettype none
// ============================================================================
//  Module      : circ_step_core
//  Description : Combinational point-by-point comparison step decision on
//                coordinate magnitudes. Picks the axis, the direction of the
//                magnitude change and the next magnitudes / deviation F.
//  Revision    : 1.0 - initial release
// ============================================================================
module circ_step_core #(
    parameter int COORD_W = 16,
    parameter int F_W     = 2*COORD_W+2
) (
    input  logic [COORD_W-2:0]    ax,
    input  logic [COORD_W-2:0]    ay,
    input  logic signed [F_W-1:0] f,
    input  logic                  m,
    output logic                  sel_x,
    output logic                  inc,
    output logic [COORD_W-2:0]    ax_n,
    output logic [COORD_W-2:0]    ay_n,
    output logic signed [F_W-1:0] f_n
);
    localparam int MAG_W = COORD_W-1;
    localparam logic signed [F_W-1:0] F_ONE   = F_W'(1);
    localparam logic [MAG_W-1:0]      MAG_ONE = MAG_W'(1);

    logic signed [F_W-1:0] ax_f;
    logic signed [F_W-1:0] ay_f;
    logic                  dec_zero;
    logic                  do_dec;

    // Magnitudes zero-extended into the deviation width.
    assign ax_f = F_W'(ax);
    assign ay_f = F_W'(ay);

    // m=1 decrements x, m=0 decrements y; an axis already at zero cannot be
    // decremented, so the other axis is incremented instead.
    assign dec_zero = m ? (ax == '0) : (ay == '0);
    assign do_dec   = ~f[F_W-1] & ~dec_zero;

    // Apply the chosen step using the old magnitudes for the F update.
    always_comb begin
        sel_x = 1'b0;
        inc   = 1'b1;
        ax_n  = ax;
        ay_n  = ay;
        f_n   = f;
        if (do_dec) begin
            inc = 1'b0;
            if (m) begin
                sel_x = 1'b1;
                ax_n  = ax - MAG_ONE;
                f_n   = f - (ax_f + ax_f) + F_ONE;
            end else begin
                sel_x = 1'b0;
                ay_n  = ay - MAG_ONE;
                f_n   = f - (ay_f + ay_f) + F_ONE;
            end
        end else begin
            if (m) begin
                sel_x = 1'b0;
                ay_n  = ay + MAG_ONE;
                f_n   = f + ay_f + ay_f + F_ONE;
            end else begin
                sel_x = 1'b1;
                ax_n  = ax + MAG_ONE;
                f_n   = f + ax_f + ax_f + F_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/circ_interp_core.sv
`default_nettype none
// ============================================================================
//  Module      : circ_interp_core
//  Description : Point-by-point comparison circular interpolator. Each rising
//                edge of pulse_clk during RUN moves the arc one unit on X or
//                Y and emits the matching step/dir pulse. Reports
//                change_readyH / draw_overH back to speed_clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module circ_interp_core
    import circ_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int F_W     = 2*COORD_W+2,
    parameter int CNT_W   = COORD_W+1
) (
    input  logic          ms_clk,
    input  logic          sys_rst_l,
    circ_interp_if.slave  bus
);
    localparam int MAG_W = COORD_W-1;
    localparam logic signed [COORD_W-1:0] POS_ONE = COORD_W'(1);
    localparam logic [CNT_W-1:0]          CNT_ONE = CNT_W'(1);

    // Magnitude of a legal signed coordinate (the most negative code is
    // excluded, so the result always fits in MAG_W bits).
    function automatic logic [MAG_W-1:0] mag(input logic signed [COORD_W-1:0] v);
        return v[COORD_W-1] ? (~v[MAG_W-1:0] + MAG_W'(1)) : v[MAG_W-1:0];
    endfunction

    logic [2:0]                state;
    logic                      pulse_q;

    // Command latched on start accept
    logic signed [COORD_W-1:0] xs_l;
    logic signed [COORD_W-1:0] ys_l;
    logic signed [COORD_W-1:0] xe_l;
    logic signed [COORD_W-1:0] ye_l;
    logic                      ccw_l;

    // Interpolation state
    logic [MAG_W-1:0]          ax;
    logic [MAG_W-1:0]          ay;
    logic                      sx;
    logic                      sy;
    logic signed [F_W-1:0]     f;
    logic [CNT_W-1:0]          n;

    // Output registers
    logic                      x_step;
    logic                      y_step;
    logic                      x_dir;
    logic                      y_dir;
    logic signed [COORD_W-1:0] x_pos;
    logic signed [COORD_W-1:0] y_pos;
    logic                      change_ready;
    logic                      draw_over;
    logic                      err;

    // Load-time arithmetic
    logic [MAG_W-1:0]          mxs;
    logic [MAG_W-1:0]          mys;
    logic [MAG_W-1:0]          mxe;
    logic [MAG_W-1:0]          mye;
    logic [MAG_W-1:0]          dx;
    logic [MAG_W-1:0]          dy;
    logic [CNT_W-1:0]          n_load;
    logic                      quad_bad;

    // Step decision
    logic                      pulse_edge;
    logic                      m;
    logic                      step_sel_x;
    logic                      step_inc;
    logic [MAG_W-1:0]          ax_next;
    logic [MAG_W-1:0]          ay_next;
    logic signed [F_W-1:0]     f_next;
    logic                      x_dir_next;
    logic                      y_dir_next;

    assign mxs = mag(xs_l);
    assign mys = mag(ys_l);
    assign mxe = mag(xe_l);
    assign mye = mag(ye_l);
    assign dx  = (mxe >= mxs) ? (mxe - mxs) : (mxs - mxe);
    assign dy  = (mye >= mys) ? (mye - mys) : (mys - mye);
    assign n_load = CNT_W'(dx) + CNT_W'(dy);

    // An end coordinate of zero sits on the axis and belongs to both adjacent
    // quadrants; only a non-zero end coordinate of opposite sign is rejected.
    assign quad_bad = ((xe_l != '0) && (xe_l[COORD_W-1] != xs_l[COORD_W-1])) ||
                      ((ye_l != '0) && (ye_l[COORD_W-1] != ys_l[COORD_W-1]));

    assign pulse_edge = bus.pulse_clk & ~pulse_q;
    assign m          = ccw_l ^ quad_mirror(quad_t'({sx, sy}));

    // Direction is positive when the magnitude grows in the positive half or
    // shrinks in the negative half.
    assign x_dir_next = sx ^ step_inc;
    assign y_dir_next = sy ^ step_inc;

    circ_step_core #(
        .COORD_W (COORD_W),
        .F_W     (F_W)
    ) u_step (
        .ax      (ax),
        .ay      (ay),
        .f       (f),
        .m       (m),
        .sel_x   (step_sel_x),
        .inc     (step_inc),
        .ax_n    (ax_next),
        .ay_n    (ay_next),
        .f_n     (f_next)
    );

    // Sample pulse_clk for rising-edge detection.
    always_ff @(posedge ms_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= bus.pulse_clk;
        end
    end

    // Control FSM with command latch, interpolation state and output registers.
    always_ff @(posedge ms_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state        <= ST_IDLE;
            xs_l         <= '0;
            ys_l         <= '0;
            xe_l         <= '0;
            ye_l         <= '0;
            ccw_l        <= 1'b0;
            ax           <= '0;
            ay           <= '0;
            sx           <= 1'b0;
            sy           <= 1'b0;
            f            <= '0;
            n            <= '0;
            x_step       <= 1'b0;
            y_step       <= 1'b0;
            x_dir        <= 1'b0;
            y_dir        <= 1'b0;
            x_pos        <= '0;
            y_pos        <= '0;
            change_ready <= 1'b0;
            draw_over    <= 1'b0;
            err          <= 1'b0;
        end else begin
            x_step       <= 1'b0;
            y_step       <= 1'b0;
            change_ready <= 1'b0;
            if (bus.stop) begin
                state     <= ST_IDLE;
                draw_over <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            xs_l      <= bus.x_start;
                            ys_l      <= bus.y_start;
                            xe_l      <= bus.x_end;
                            ye_l      <= bus.y_end;
                            ccw_l     <= bus.ccw;
                            err       <= 1'b0;
                            draw_over <= 1'b0;
                            state     <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        ax    <= mxs;
                        ay    <= mys;
                        sx    <= xs_l[COORD_W-1];
                        sy    <= ys_l[COORD_W-1];
                        x_pos <= xs_l;
                        y_pos <= ys_l;
                        f     <= '0;
                        n     <= n_load;
                        if (quad_bad) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            change_ready <= 1'b1;
                            state        <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (n == '0) begin
                            draw_over <= 1'b1;
                            state     <= ST_DONE;
                        end else if (pulse_edge) begin
                            ax <= ax_next;
                            ay <= ay_next;
                            f  <= f_next;
                            n  <= n - CNT_ONE;
                            if (step_sel_x) begin
                                x_step <= 1'b1;
                                x_dir  <= x_dir_next;
                                x_pos  <= x_dir_next ? (x_pos + POS_ONE) : (x_pos - POS_ONE);
                            end else begin
                                y_step <= 1'b1;
                                y_dir  <= y_dir_next;
                                y_pos  <= y_dir_next ? (y_pos + POS_ONE) : (y_pos - POS_ONE);
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.x_step        = x_step;
    assign bus.y_step        = y_step;
    assign bus.x_dir         = x_dir;
    assign bus.y_dir         = y_dir;
    assign bus.x_pos         = x_pos;
    assign bus.y_pos         = y_pos;
    assign bus.busy          = (state == ST_LOAD) || (state == ST_RUN);
    assign bus.change_readyH = change_ready;
    assign bus.draw_overH    = draw_over;
    assign bus.err           = err;

endmodule
`default_nettype wire

// File: tb/tb_circ_interp_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_circ_interp_core
//  Description : Scoreboard bench for circ_interp_core. Expected events are
//                queued with each command; a monitor pops and compares every
//                step, change_readyH, draw_overH rise and err rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_circ_interp_core;

    localparam int EV_CR   = 0;
    localparam int EV_XS   = 1;
    localparam int EV_YS   = 2;
    localparam int EV_DONE = 3;
    localparam int EV_ERR  = 4;

    typedef struct {
        int                 tag;
        int                 idx;
        int                 kind;
        logic               dir;
        logic signed [15:0] x;
        logic signed [15:0] y;
    } ev_t;

    logic ms_clk    = 1'b0;
    logic sys_rst_l = 1'b0;
    logic pulse_en  = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   steps_seen  = 0;
    ev_t  sb[$];

    // Hand-computed arcs: Q1 CCW (5,0)->(0,5) and Q3 CW (-3,-4)->(-5,0).
    int t1_k [10] = '{EV_XS, EV_YS, EV_YS, EV_YS, EV_XS, EV_YS, EV_XS, EV_YS, EV_XS, EV_XS};
    int t1_d [10] = '{0, 1, 1, 1, 0, 1, 0, 1, 0, 0};
    int t1_x [10] = '{4, 4, 4, 4, 3, 3, 2, 2, 1, 0};
    int t1_y [10] = '{0, 1, 2, 3, 3, 4, 4, 5, 5, 5};
    int t2_k [6]  = '{EV_YS, EV_XS, EV_YS, EV_XS, EV_YS, EV_YS};
    int t2_d [6]  = '{1, 0, 1, 0, 1, 1};
    int t2_x [6]  = '{-3, -4, -4, -5, -5, -5};
    int t2_y [6]  = '{-3, -3, -2, -2, -1, 0};

    circ_interp_if #(.COORD_W(16)) bus ();

    circ_interp_core #(.COORD_W(16)) dut (
        .ms_clk    (ms_clk),
        .sys_rst_l (sys_rst_l),
        .bus       (bus)
    );

    always #5 ms_clk = ~ms_clk;

    function automatic string kname(input int k);
        case (k)
            EV_CR:   return "change_readyH";
            EV_XS:   return "x_step";
            EV_YS:   return "y_step";
            EV_DONE: return "draw_overH";
            default: return "err";
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int tag, input int idx, input int kind, input int dir,
                        input int x, input int y);
        ev_t e;
        e.tag  = tag;
        e.idx  = idx;
        e.kind = kind;
        e.dir  = dir[0];
        e.x    = 16'(x);
        e.y    = 16'(y);
        sb.push_back(e);
    endtask

    task automatic push_arc1(input int tag, input int nsteps, input bit with_done);
        push(tag, 0, EV_CR, 0, 5, 0);
        for (int i = 0; i < nsteps; i++) push(tag, i + 1, t1_k[i], t1_d[i], t1_x[i], t1_y[i]);
        if (with_done) push(tag, 99, EV_DONE, 0, 0, 5);
    endtask

    task automatic observe(input int kind, input logic dir,
                           input logic signed [15:0] x, input logic signed [15:0] y);
        ev_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected event: got %s dir=%0d at (%0d,%0d), required none",
                     kname(kind), dir, x, y);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.x != x || e.y != y ||
                ((kind == EV_XS || kind == EV_YS) && e.dir != dir)) begin
                miscompares++;
                $display("FAIL ev t%0d.%0d: got %s dir=%0d (%0d,%0d), required %s dir=%0d (%0d,%0d)",
                         e.tag, e.idx, kname(kind), dir, x, y, kname(e.kind), e.dir, e.x, e.y);
            end
        end
    endtask

    // Monitor: compare every DUT event against the scoreboard queue.
    initial begin : monitor
        logic prev_done;
        logic prev_err;
        prev_done = 1'b0;
        prev_err  = 1'b0;
        forever begin
            @(negedge ms_clk);
            if (!sys_rst_l) begin
                prev_done = 1'b0;
                prev_err  = 1'b0;
            end else begin
                if (bus.change_readyH) observe(EV_CR, 1'b0, bus.x_pos, bus.y_pos);
                if (bus.x_step) begin
                    steps_seen++;
                    observe(EV_XS, bus.x_dir, bus.x_pos, bus.y_pos);
                end
                if (bus.y_step) begin
                    steps_seen++;
                    observe(EV_YS, bus.y_dir, bus.x_pos, bus.y_pos);
                end
                if (bus.draw_overH && !prev_done) observe(EV_DONE, 1'b0, bus.x_pos, bus.y_pos);
                if (bus.err && !prev_err) observe(EV_ERR, 1'b0, bus.x_pos, bus.y_pos);
                prev_done = bus.draw_overH;
                prev_err  = bus.err;
            end
        end
    end

    // Step-rate source: one-cycle pulse every 8 clocks while enabled.
    initial begin : pulse_gen
        int cnt;
        cnt = 0;
        bus.pulse_clk = 1'b0;
        forever begin
            @(posedge ms_clk);
            #1;
            if (pulse_en) begin
                cnt++;
                bus.pulse_clk = (cnt % 8 == 0);
            end else begin
                bus.pulse_clk = 1'b0;
            end
        end
    end

    task automatic start_arc(input logic dir_ccw, input int xs, input int ys,
                             input int xe, input int ye);
        @(posedge ms_clk);
        #1;
        bus.ccw     = dir_ccw;
        bus.x_start = 16'(xs);
        bus.y_start = 16'(ys);
        bus.x_end   = 16'(xe);
        bus.y_end   = 16'(ye);
        bus.start   = 1'b1;
        @(posedge ms_clk);
        #1;
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !bus.draw_overH; i++) @(negedge ms_clk);
        vectors++;
        if (!bus.draw_overH) begin
            miscompares++;
            $display("FAIL %s: draw_overH still 0 after %0d cycles, required 1", name, budget);
        end
        @(negedge ms_clk);
    endtask

    task automatic wait_steps(input string name, input int target, input int budget);
        for (int i = 0; i < budget && steps_seen < target; i++) @(negedge ms_clk);
        vectors++;
        if (steps_seen < target) begin
            miscompares++;
            $display("FAIL %s: saw %0d steps, required %0d", name, steps_seen, target);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.x_step, bus.y_step, bus.x_dir, bus.y_dir, bus.x_pos, bus.y_pos,
                     bus.busy, bus.change_readyH, bus.draw_overH, bus.err}, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.ccw     = 1'b0;
        bus.x_start = '0;
        bus.y_start = '0;
        bus.x_end   = '0;
        bus.y_end   = '0;

        // Reset state
        repeat (3) @(negedge ms_clk);
        check_all_zero("reset outputs");
        @(posedge ms_clk);
        #1;
        sys_rst_l = 1'b1;
        pulse_en  = 1'b1;
        repeat (2) @(negedge ms_clk);
        check_all_zero("idle outputs");

        // 1: Q1 CCW (5,0)->(0,5)
        push_arc1(1, 10, 1'b1);
        start_arc(1'b1, 5, 0, 0, 5);
        @(negedge ms_clk);
        check("t1 busy in LOAD", bus.busy, 1);
        wait_done("t1 done", 400);
        check("t1 queue drained", sb.size(), 0);
        repeat (5) @(negedge ms_clk);
        check("t1 draw_overH held", bus.draw_overH, 1);
        check("t1 busy after done", bus.busy, 0);

        // 2: Q3 CW (-3,-4)->(-5,0)
        push(2, 0, EV_CR, 0, -3, -4);
        for (int i = 0; i < 6; i++) push(2, i + 1, t2_k[i], t2_d[i], t2_x[i], t2_y[i]);
        push(2, 99, EV_DONE, 0, -5, 0);
        start_arc(1'b0, -3, -4, -5, 0);
        @(negedge ms_clk);
        check("t2 draw_overH cleared", bus.draw_overH, 0);
        wait_done("t2 done", 300);
        check("t2 queue drained", sb.size(), 0);

        // 3: cross-quadrant (5,0)->(-3,4)
        push(3, 0, EV_ERR, 0, 5, 0);
        start_arc(1'b1, 5, 0, -3, 4);
        @(negedge ms_clk);
        check("t3 busy in LOAD", bus.busy, 1);
        @(negedge ms_clk);
        check("t3 err", bus.err, 1);
        check("t3 idle", bus.busy, 0);
        repeat (30) @(negedge ms_clk);
        check("t3 err sticky", bus.err, 1);
        check("t3 pos", {bus.x_pos, bus.y_pos}, {16'sd5, 16'sd0});
        check("t3 queue drained", sb.size(), 0);

        // 4: zero-length arc at (3,4)
        push(4, 0, EV_CR, 0, 3, 4);
        push(4, 99, EV_DONE, 0, 3, 4);
        start_arc(1'b1, 3, 4, 3, 4);
        @(negedge ms_clk);
        check("t4 err cleared", bus.err, 0);
        @(negedge ms_clk);
        check("t4 change_readyH", bus.change_readyH, 1);
        check("t4 draw_overH early", bus.draw_overH, 0);
        @(negedge ms_clk);
        check("t4 draw_overH", bus.draw_overH, 1);
        repeat (20) @(negedge ms_clk);
        check("t4 queue drained", sb.size(), 0);

        // 5: stop after the 3rd step of arc 1
        base = steps_seen;
        push_arc1(5, 3, 1'b0);
        start_arc(1'b1, 5, 0, 0, 5);
        wait_steps("t5 three steps", base + 3, 200);
        @(posedge ms_clk);
        #1;
        bus.stop = 1'b1;
        @(posedge ms_clk);
        #1;
        bus.stop = 1'b0;
        repeat (40) @(negedge ms_clk);
        check("t5 draw_overH", bus.draw_overH, 0);
        check("t5 busy", bus.busy, 0);
        check("t5 pos", {bus.x_pos, bus.y_pos}, {16'sd4, 16'sd2});
        check("t5 queue drained", sb.size(), 0);

        // 6: reset mid-RUN, then the full arc again
        base = steps_seen;
        push_arc1(6, 2, 1'b0);
        start_arc(1'b1, 5, 0, 0, 5);
        wait_steps("t6 two steps", base + 2, 200);
        @(posedge ms_clk);
        #1;
        sys_rst_l = 1'b0;
        @(negedge ms_clk);
        check_all_zero("t6 outputs in reset");
        check("t6 queue drained", sb.size(), 0);
        repeat (3) @(posedge ms_clk);
        #1;
        sys_rst_l = 1'b1;
        push_arc1(7, 10, 1'b1);
        start_arc(1'b1, 5, 0, 0, 5);
        wait_done("t6 rerun done", 400);
        check("t6 rerun queue drained", sb.size(), 0);
        check("t6 rerun pos", {bus.x_pos, bus.y_pos}, {16'sd0, 16'sd5});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
